// File: rtl/fifo_ctrl.sv
// fifo_ctrl: synchronous FIFO controller for a simple dual-port memory.
// The controller owns the memory write and read ports and tracks the
// pointers and occupancy. A two-entry output buffer absorbs the one-cycle
// read latency so that the read side can stream at one word per cycle.
// Optional feature: define FIFO_CTRL_ALMOST_EN to add the registered
// almost_full and almost_empty flags.
module fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LVL_WIDTH  = $clog2(DEPTH + 3)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
`ifdef FIFO_CTRL_ALMOST_EN
  output logic                  almost_full,
  output logic                  almost_empty,
`endif
  output logic [LVL_WIDTH-1:0]  level
);

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [LVL_WIDTH-1:0]  mem_cnt;
  logic                  inflight;
  logic [1:0]            ob_cnt;
  logic [DATA_WIDTH-1:0] ob_data [2];

  logic                  push;
  logic                  pop;
  logic [1:0]            ob_cnt_nxt;
  logic                  ob_wr_sel;
  logic [LVL_WIDTH-1:0]  mem_cnt_nxt;

  // Pointer increment with explicit wrap so DEPTH need not be a power of two.
  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == ADDR_WIDTH'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshakes, read-issue decision and next-state counters.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    s_ready     = rst_n & (mem_cnt != LVL_WIDTH'(DEPTH));
    push        = s_valid & s_ready;
    m_valid     = (ob_cnt != 2'd0);
    pop         = m_valid & m_ready;
    ob_cnt_nxt  = ob_cnt + {1'b0, inflight} - {1'b0, pop};
    // Issue a read only if the buffer still has room once this cycle settles.
    mem_rd_en   = (mem_cnt != '0) & (ob_cnt_nxt < 2'd2);
    // Returning word lands at slot ob_cnt - pop, which is always 0 or 1.
    ob_wr_sel   = (ob_cnt == 2'd2) | ((ob_cnt == 2'd1) & ~pop);
    mem_cnt_nxt = mem_cnt + LVL_WIDTH'(push) - LVL_WIDTH'(mem_rd_en);
  end

  assign mem_wr_en   = push;
  assign mem_wr_addr = wptr;
  assign mem_wr_data = s_data;
  assign mem_rd_addr = rptr;
  assign m_data      = ob_data[0];
  assign level       = mem_cnt + LVL_WIDTH'(inflight) + LVL_WIDTH'(ob_cnt);

  // Pointers, occupancy and in-flight tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
      ob_cnt   <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (push)      wptr <= ptr_inc(wptr);
      if (mem_rd_en) rptr <= ptr_inc(rptr);
      mem_cnt  <= mem_cnt_nxt;
      inflight <= mem_rd_en;
      ob_cnt   <= ob_cnt_nxt;
    end
  end

  // Output buffer: shift on pop, then capture returning read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: only two entries, so resetting them is cheap and gives m_data a defined reset value.
      ob_data[0] <= '0;
      ob_data[1] <= '0;
    end else begin
      if (pop)      ob_data[0] <= ob_data[1];
      if (inflight) ob_data[ob_wr_sel] <= mem_rd_data;
    end
  end

`ifdef FIFO_CTRL_ALMOST_EN
  logic [LVL_WIDTH-1:0] level_nxt;
  assign level_nxt = mem_cnt_nxt + LVL_WIDTH'(mem_rd_en) + LVL_WIDTH'(ob_cnt_nxt);

  // Threshold flags registered alongside the counters they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (mem_cnt_nxt >= LVL_WIDTH'(DEPTH - 1));
      almost_empty <= (level_nxt <= LVL_WIDTH'(1));
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed bench for fifo_ctrl with a behavioural model of
// the downstream memory (write on the edge, read data registered one cycle
// after the read enable). Inputs change 1 time unit after each rising edge;
// outputs are sampled 3 time units after it.
module tb_fifo_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = $clog2(DEPTH + 3);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic [LW-1:0] level;
`ifdef FIFO_CTRL_ALMOST_EN
  logic          almost_full;
  logic          almost_empty;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
`ifdef FIFO_CTRL_ALMOST_EN
    .almost_full (almost_full),
    .almost_empty(almost_empty),
`endif
    .level       (level)
  );

  always #5 clk = ~clk;

  // Memory model: contents survive reset.
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_valid"},  32'(m_valid),     32'd0);
    check({tag, "_s_ready"},  32'(s_ready),     32'd0);
    check({tag, "_wr_en"},    32'(mem_wr_en),   32'd0);
    check({tag, "_rd_en"},    32'(mem_rd_en),   32'd0);
    check({tag, "_wr_addr"},  32'(mem_wr_addr), 32'd0);
    check({tag, "_rd_addr"},  32'(mem_rd_addr), 32'd0);
    check({tag, "_level"},    32'(level),       32'd0);
    check({tag, "_m_data"},   32'(m_data),      32'd0);
  endtask

  int            sent;
  int            got;
  logic          held;
  logic [DW-1:0] held_data;

  initial begin
    // ---------------- Reset, then single word ----------------
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hA5;
    m_ready = 1'b1;
    #2;
    check_reset_outputs("por");
`ifdef FIFO_CTRL_ALMOST_EN
    check("por_almost_empty", 32'(almost_empty), 32'd1);
    check("por_almost_full",  32'(almost_full),  32'd0);
`endif
    next_cycle();
    rst_n = 1'b1;
    #2;
    check("sw_c0_s_ready", 32'(s_ready),     32'd1);
    check("sw_c0_wr_en",   32'(mem_wr_en),   32'd1);
    check("sw_c0_wr_addr", 32'(mem_wr_addr), 32'd0);
    check("sw_c0_rd_en",   32'(mem_rd_en),   32'd0);
    next_cycle();
    s_valid = 1'b0;
    #2;
    check("sw_c1_rd_en",   32'(mem_rd_en),   32'd1);
    check("sw_c1_rd_addr", 32'(mem_rd_addr), 32'd0);
    check("sw_c1_level",   32'(level),       32'd1);
    check("sw_c1_m_valid", 32'(m_valid),     32'd0);
    next_cycle();
    #2;
    check("sw_c2_m_valid", 32'(m_valid), 32'd0);
    check("sw_c2_level",   32'(level),   32'd1);
    next_cycle();
    #2;
    check("sw_c3_m_valid", 32'(m_valid), 32'd1);
    check("sw_c3_m_data",  32'(m_data),  32'hA5);
    next_cycle();
    #2;
    check("sw_c4_m_valid", 32'(m_valid), 32'd0);
    check("sw_c4_level",   32'(level),   32'd0);
    next_cycle();

    // ---------------- Fill to full (pointers start at 1) ----------------
    m_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i);
      #2;
      check("fill_s_ready", 32'(s_ready),   32'd1);
      check("fill_wr_en",   32'(mem_wr_en), 32'd1);
      next_cycle();
    end
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_data  = 8'hFF;
      #2;
      check("full_s_ready", 32'(s_ready),   32'd0);
      check("full_wr_en",   32'(mem_wr_en), 32'd0);
      check("full_rd_en",   32'(mem_rd_en), 32'd0);
      check("full_level",   32'(level),     32'd18);
      check("full_m_valid", 32'(m_valid),   32'd1);
      check("full_m_data",  32'(m_data),    32'h00);
      next_cycle();
    end

    // ---------------- Full plus simultaneous read ----------------
    s_valid = 1'b0;
    m_ready = 1'b1;
    #2;
    check("fr_pop_m_data",  32'(m_data),      32'h00);
    check("fr_pop_rd_en",   32'(mem_rd_en),   32'd1);
    check("fr_pop_rd_addr", 32'(mem_rd_addr), 32'd3);
    check("fr_pop_s_ready", 32'(s_ready),     32'd0);
    next_cycle();
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h12;
    #2;
    check("fr_next_s_ready", 32'(s_ready),     32'd1);
    check("fr_next_wr_en",   32'(mem_wr_en),   32'd1);
    check("fr_next_wr_addr", 32'(mem_wr_addr), 32'd3);
    check("fr_next_rd_en",   32'(mem_rd_en),   32'd0);
    check("fr_next_m_data",  32'(m_data),      32'h01);
    check("fr_next_level",   32'(level),       32'd17);
    next_cycle();
    s_valid = 1'b0;
    #2;
    check("fr_refull_s_ready", 32'(s_ready), 32'd0);
    check("fr_refull_level",   32'(level),   32'd18);
    check("fr_refull_m_data",  32'(m_data),  32'h01);
    next_cycle();

    // Drain: 0x01..0x12 at one word per cycle.
    m_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      #2;
      check("drain_m_valid", 32'(m_valid), 32'd1);
      check("drain_m_data",  32'(m_data),  32'(i + 1));
      next_cycle();
    end
    #2;
    check("drain_end_m_valid", 32'(m_valid), 32'd0);
    check("drain_end_level",   32'(level),   32'd0);
    next_cycle();

    // ---------------- Streaming with wrap (pointers start at 4) ----------------
    for (int c = 0; c < 43; c++) begin
      s_valid = (c < 40);
      s_data  = 8'(8'h80 + c);
      m_ready = 1'b1;
      #2;
      if (c < 40) begin
        check("st_s_ready", 32'(s_ready),     32'd1);
        check("st_wr_addr", 32'(mem_wr_addr), 32'((4 + c) % DEPTH));
      end
      if (c >= 1 && c <= 40) begin
        check("st_rd_en",   32'(mem_rd_en),   32'd1);
        check("st_rd_addr", 32'(mem_rd_addr), 32'((3 + c) % DEPTH));
      end
      if (c >= 3) begin
        check("st_m_valid", 32'(m_valid), 32'd1);
        check("st_m_data",  32'(m_data),  32'(8'(8'h80 + c - 3)));
      end
      next_cycle();
    end
    s_valid = 1'b0;
    #2;
    check("st_end_m_valid", 32'(m_valid), 32'd0);
    check("st_end_level",   32'(level),   32'd0);
    next_cycle();

    // ---------------- Backpressure: m_ready toggles every cycle ----------------
    sent = 0;
    got  = 0;
    held = 1'b0;
    held_data = '0;
    for (int k = 0; k < 200 && got < 20; k++) begin
      m_ready = (k % 2 == 1);
      s_valid = (sent < 20);
      s_data  = 8'(8'hC0 + sent);
      #2;
      if (held) begin
        check("bp_hold_valid", 32'(m_valid), 32'd1);
        check("bp_hold_data",  32'(m_data),  32'(held_data));
      end
      held = 1'b0;
      if (m_valid && m_ready) begin
        check("bp_data", 32'(m_data), 32'(8'(8'hC0 + got)));
        got++;
      end else if (m_valid) begin
        check("bp_stall_data", 32'(m_data), 32'(8'(8'hC0 + got)));
        held      = 1'b1;
        held_data = m_data;
      end
      if (s_valid && s_ready) sent++;
      next_cycle();
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    check("bp_words_out", 32'(got), 32'd20);
    #2;
    check("bp_end_level", 32'(level), 32'd0);
    next_cycle();

    // ---------------- Mid-operation reset ----------------
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h50 + i);
      #2;
      check("mr_fill_s_ready", 32'(s_ready), 32'd1);
      next_cycle();
    end
    s_valid = 1'b0;
    #2;
    check("mr_idle_level",  32'(level),  32'd6);
    check("mr_idle_m_data", 32'(m_data), 32'h50);
    next_cycle();
    m_ready = 1'b1;
    #2;
    check("mr_pop_rd_en",  32'(mem_rd_en), 32'd1);
    check("mr_pop_m_data", 32'(m_data),    32'h50);
    next_cycle();
    m_ready = 1'b0;
    #2;
    check("mr_pre_level",   32'(level),   32'd5);
    check("mr_pre_m_valid", 32'(m_valid), 32'd1);
    check("mr_pre_m_data",  32'(m_data),  32'h51);
    s_valid = 1'b1;
    s_data  = 8'h3C;
    rst_n   = 1'b0;
    #1;
    check_reset_outputs("mr_async");
    next_cycle();
    check_reset_outputs("mr_held");
    rst_n   = 1'b1;
    m_ready = 1'b1;
    #2;
    check("mr_c0_wr_en",   32'(mem_wr_en),   32'd1);
    check("mr_c0_wr_addr", 32'(mem_wr_addr), 32'd0);
    check("mr_c0_m_valid", 32'(m_valid),     32'd0);
    next_cycle();
    s_valid = 1'b0;
    #2;
    check("mr_c1_rd_en",   32'(mem_rd_en),   32'd1);
    check("mr_c1_rd_addr", 32'(mem_rd_addr), 32'd0);
    check("mr_c1_m_valid", 32'(m_valid),     32'd0);
    next_cycle();
    #2;
    check("mr_c2_m_valid", 32'(m_valid), 32'd0);
    next_cycle();
    #2;
    check("mr_c3_m_valid", 32'(m_valid), 32'd1);
    check("mr_c3_m_data",  32'(m_data),  32'h3C);
    next_cycle();
    #2;
    check("mr_c4_level", 32'(level), 32'd0);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
